// File: rtl/tx_zc_sched.sv
// Round-robin scheduler sharing one ZC phase generator among NUM_REQ requesters.
// Grants a requester, loads its config, pulses start, and acks on end, reject or timeout.
module tx_zc_sched #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*85-1:0] req_cfg,
  output logic [NUM_REQ-1:0]    ack,
  output logic                 ack_err,
  output logic [1:0]           gnt_idx,
  output logic [4:0]           zc_u,
  output logic [4:0]           zc_v,
  output logic [4:0]           zc_alpha,
  output logic [11:0]          zc_start_index,
  output logic [11:0]          zc_len,
  output logic [11:0]          zc_N_zc,
  output logic [14:0]          zc_Q,
  output logic [15:0]          zc_P,
  output logic                 zc_start,
  input  logic                 zc_busy,
  input  logic                 zc_end,
  output logic                 sched_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitEnd,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sel_q;
  logic [1:0]  gnt_idx_q;
  logic [1:0]  last_gnt_q;
  logic [11:0] cnt_q;
  logic [81:0] cfg_q;

  logic [81:0] cfg_sel;
  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;
  logic        cfg_bad;

  // Packed fields occupy the low 82 bits of each 85-bit slice; the top 3 bits are reserved.
  assign cfg_sel = req_cfg[32'(sel_q) * 85 +: 82];
  assign cfg_bad = (cfg_sel[42:31] < 12'd30) || (cfg_sel[54:43] == 12'd0);

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 2'((32'(last_gnt_q) + 32'd1 + i) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !zc_busy) state_d = StLoad;
      end
      StLoad: begin
        state_d = cfg_bad ? StErr : StStart;
      end
      StStart: begin
        state_d = StWaitEnd;
      end
      StWaitEnd: begin
        // End-of-sequence wins over a coincident timeout.
        if (zc_end) begin
          state_d = StDone;
        end else if (cnt_q == 12'(TIMEOUT)) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      gnt_idx_q  <= '0;
      last_gnt_q <= 2'(NUM_REQ - 1);
      cnt_q      <= '0;
      cfg_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && pick_valid && !zc_busy) begin
        sel_q <= pick_idx;
      end
      if (state_q == StLoad) begin
        gnt_idx_q <= sel_q;
        cfg_q     <= cfg_sel;
      end
      if (state_q == StStart) begin
        cnt_q <= '0;
      end else if (state_q == StWaitEnd) begin
        cnt_q <= cnt_q + 12'd1;
      end
      if (state_q == StDone || state_q == StErr) begin
        last_gnt_q <= gnt_idx_q;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == StDone || state_q == StErr) ack[gnt_idx_q] = 1'b1;
  end

  assign ack_err        = (state_q == StErr);
  assign zc_start       = (state_q == StStart);
  assign sched_busy     = (state_q != StIdle);
  assign gnt_idx        = gnt_idx_q;
  assign zc_u           = cfg_q[81:77];
  assign zc_v           = cfg_q[76:72];
  assign zc_alpha       = cfg_q[71:67];
  assign zc_start_index = cfg_q[66:55];
  assign zc_len         = cfg_q[54:43];
  assign zc_N_zc        = cfg_q[42:31];
  assign zc_Q           = cfg_q[30:16];
  assign zc_P           = cfg_q[15:0];

endmodule
